// File: rtl/wb_cmd_master_if.sv
// Command port plus Wishbone pipelined bus bundle for wb_cmd_master.
// The master modport is the initiator's view; the slave modport is the bus/command-source view.
interface wb_cmd_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_data;
    logic [DW/8-1:0]   cmd_sel;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic              o_wb_we;
    logic [AW-1:0]     o_wb_addr;
    logic [DW-1:0]     o_wb_data;
    logic [DW/8-1:0]   o_wb_sel;
    logic              i_wb_stall;
    logic              i_wb_ack;
    logic [DW-1:0]     i_wb_data;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
        input  i_wb_stall, i_wb_ack, i_wb_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel,
        output i_wb_stall, i_wb_ack, i_wb_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone pipelined initiator: one bus transaction per local command, with read-data
// return and a cycle-count timeout abort.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// REQ   | cyc/stb high, waiting for the slave to drop stall
// WAIT  | request accepted, cyc high, waiting for ack
// RESP  | one-cycle rsp_valid pulse, bus released
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    wb_cmd_master_if.master    bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);

    state_t            state, state_nxt;
    logic [15:0]       tmo_cnt, tmo_cnt_nxt;
    logic [16:0]       tmo_inc;
    logic              tmo_hit;
    logic              fin_ok, fin_tmo;
    logic              ready_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [DW-1:0]     rsp_data_nxt;
    logic              cyc_nxt, stb_nxt, we_nxt;
    logic [AW-1:0]     addr_nxt;
    logic [DW-1:0]     wdata_nxt;
    logic [DW/8-1:0]   sel_nxt;

    assign tmo_inc = {1'b0, tmo_cnt} + 17'd1;
    assign tmo_hit = (tmo_inc == TMO_LIMIT);

    always_comb begin
        state_nxt     = state;
        tmo_cnt_nxt   = tmo_cnt;
        ready_nxt     = bus.cmd_ready;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = bus.rsp_err;
        rsp_data_nxt  = bus.rsp_data;
        cyc_nxt       = bus.o_wb_cyc;
        stb_nxt       = bus.o_wb_stb;
        we_nxt        = bus.o_wb_we;
        addr_nxt      = bus.o_wb_addr;
        wdata_nxt     = bus.o_wb_data;
        sel_nxt       = bus.o_wb_sel;
        fin_ok        = 1'b0;
        fin_tmo       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    we_nxt      = bus.cmd_we;
                    addr_nxt    = bus.cmd_addr;
                    wdata_nxt   = bus.cmd_data;
                    sel_nxt     = bus.cmd_sel;
                    cyc_nxt     = 1'b1;
                    stb_nxt     = 1'b1;
                    ready_nxt   = 1'b0;
                    tmo_cnt_nxt = '0;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                tmo_cnt_nxt = tmo_inc[15:0];
                // an ack is only meaningful once the request has been taken (stall low)
                if (!bus.i_wb_stall) begin
                    stb_nxt = 1'b0;
                    if (bus.i_wb_ack)  fin_ok    = 1'b1;
                    else if (tmo_hit)  fin_tmo   = 1'b1;
                    else               state_nxt = WAIT;
                end else if (tmo_hit) begin
                    fin_tmo = 1'b1;
                end
            end
            WAIT: begin
                tmo_cnt_nxt = tmo_inc[15:0];
                if (bus.i_wb_ack)  fin_ok  = 1'b1;
                else if (tmo_hit)  fin_tmo = 1'b1;
            end
            RESP: begin
                state_nxt    = IDLE;
                ready_nxt    = 1'b1;
                rsp_err_nxt  = 1'b0;
                rsp_data_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase

        // ack has priority over a timeout landing on the same edge
        if (fin_ok || fin_tmo) begin
            state_nxt     = RESP;
            cyc_nxt       = 1'b0;
            stb_nxt       = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = fin_tmo;
            rsp_data_nxt  = (fin_ok && !bus.o_wb_we) ? bus.i_wb_data : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
            bus.o_wb_cyc  <= 1'b0;
            bus.o_wb_stb  <= 1'b0;
            bus.o_wb_we   <= 1'b0;
            bus.o_wb_addr <= '0;
            bus.o_wb_data <= '0;
            bus.o_wb_sel  <= '0;
        end else begin
            state         <= state_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            bus.cmd_ready <= ready_nxt;
            bus.rsp_valid <= rsp_valid_nxt;
            bus.rsp_err   <= rsp_err_nxt;
            bus.rsp_data  <= rsp_data_nxt;
            bus.o_wb_cyc  <= cyc_nxt;
            bus.o_wb_stb  <= stb_nxt;
            bus.o_wb_we   <= we_nxt;
            bus.o_wb_addr <= addr_nxt;
            bus.o_wb_data <= wdata_nxt;
            bus.o_wb_sel  <= sel_nxt;
        end
    end
endmodule
